// File: rtl/score_bcd_converter_pkg.sv
// Shared types and limits for the score overlay: score width, saturation value,
// BCD digit types and the converter state encoding.
package score_bcd_converter_pkg;

  localparam int SCORE_WIDTH = 14;
  localparam int SCORE_MAX   = 9999;
  localparam int BCD_DIGITS  = 4;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [BCD_DIGITS-1:0] bcd_score_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets 3 added so the
// following left shift carries cleanly into the next decimal digit.
module bcd_add3
  import score_bcd_converter_pkg::*;
(
  input  bcd_digit_t nibble,
  output bcd_digit_t corrected
);

  // 4-bit add, no carry out; inputs never exceed 9 for a saturated score
  assign corrected = (nibble >= 4'd5) ? bcd_digit_t'(nibble + 4'd3) : nibble;

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD converter for the score overlay (one bit per cycle).
// Optional leading-zero blank mask is compiled in with SCORE_BCD_LEADING_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3 / shift iteration per cycle, 14 iterations
// DONE  | publish accumulator to digits, pulse done
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int SCORE_WIDTH = score_bcd_converter_pkg::SCORE_WIDTH,
  parameter int SCORE_MAX   = score_bcd_converter_pkg::SCORE_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SCORE_WIDTH-1:0] score,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output bcd_score_t             digits,
  output logic [BCD_DIGITS-1:0]  blank
);

  localparam int CNT_W = $clog2(SCORE_WIDTH);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(SCORE_WIDTH - 1);
  localparam logic [SCORE_WIDTH-1:0] MAX_VAL  = SCORE_WIDTH'(SCORE_MAX);

  bcd_state_t                state_q, state_nxt;
  logic [SCORE_WIDTH-1:0]    bin_q;
  bcd_score_t                bcd_q;
  bcd_score_t                bcd_adj;
  logic [4*BCD_DIGITS-1:0]   bcd_flat;
  logic [CNT_W-1:0]          cnt_q;
  logic [SCORE_WIDTH-1:0]    score_sat;
  logic                      load, shift_en, commit;

  assign score_sat = (score > MAX_VAL) ? MAX_VAL : score;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (bcd_q[i]),
      .corrected (bcd_adj[i])
    );
  end

  assign bcd_flat = bcd_adj;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt_q == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      bin_q <= score_sat;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      bcd_q <= {bcd_flat[4*BCD_DIGITS-2:0], bin_q[SCORE_WIDTH-1]};
      bin_q <= {bin_q[SCORE_WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // digits only ever change here, so the renderer never sees a partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      valid  <= 1'b0;
      digits <= '0;
    end else begin
      done <= commit;
      if (commit) begin
        digits <= bcd_q;
        valid  <= 1'b1;
      end
    end
  end

`ifdef SCORE_BCD_LEADING_BLANK_EN
  logic [BCD_DIGITS-1:0] blank_nxt;

  always_comb begin
    blank_nxt    = '0;
    blank_nxt[3] = (bcd_q[3] == 4'd0);
    blank_nxt[2] = blank_nxt[3] && (bcd_q[2] == 4'd0);
    blank_nxt[1] = blank_nxt[2] && (bcd_q[1] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst)         blank <= 4'b1110;
    else if (commit) blank <= blank_nxt;
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter with a queue scoreboard of expected digits/blank.
// Honours SCORE_BCD_LEADING_BLANK_EN for the blank expectations.
module tb_score_bcd_converter;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [13:0]     score;
  logic            busy, done, valid;
  logic [3:0][3:0] digits;
  logic [3:0]      blank;

  int checks = 0;
  int fails  = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  score_bcd_converter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .score  (score),
    .busy   (busy),
    .done   (done),
    .valid  (valid),
    .digits (digits),
    .blank  (blank)
  );

  function automatic logic [15:0] to_bcd(input int s);
    int v;
    v = (s > 9999) ? 9999 : s;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] blank_of(input logic [15:0] d);
    logic [3:0] b;
    b = 4'b0000;
`ifdef SCORE_BCD_LEADING_BLANK_EN
    b[3] = (d[15:12] == 4'd0);
    b[2] = b[3] && (d[11:8] == 4'd0);
    b[1] = b[2] && (d[7:4] == 4'd0);
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic accept(input int s);
    logic [15:0] d;
    start = 1'b1;
    score = 14'(s);
    @(negedge clk);
    start = 1'b0;
    score = 14'($urandom);
    d = to_bcd(s);
    exp_q.push_back({blank_of(d), d});
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int inj_cyc, input int inj_score);
    int cyc;
    bit seen;
    logic [19:0] e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (cyc == inj_cyc) begin
        start = 1'b1;
        score = 14'(inj_score);
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) seen = 1'b1;
      else if (cyc < 15) chk("busy_running", 32'(busy), 32'd1);
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(cyc), 32'd15);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("valid_at_done", 32'(valid), 32'd1);
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("digits", 32'(digits), 32'(e[15:0]));
        chk("blank", 32'(blank), 32'(e[19:16]));
      end
    end
  endtask

  task automatic post_check();
    logic [15:0] held;
    held = digits;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("digits_hold", 32'(digits), 32'(held));
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    score = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
`ifdef SCORE_BCD_LEADING_BLANK_EN
    chk("rst_blank", 32'(blank), 32'b1110);
`else
    chk("rst_blank", 32'(blank), 32'b0000);
`endif
    rst = 1'b0;
    @(negedge clk);

    accept(0);     wait_done(-1, 0); post_check();
    accept(1234);  wait_done(-1, 0); post_check();
    accept(12000); wait_done(-1, 0); post_check();
    accept(16383); wait_done(-1, 0); post_check();

    // start during a run is dropped; start on the done cycle is accepted
    accept(42);    wait_done(5, 7777);
    accept(7777);  wait_done(-1, 0); post_check();

    accept(5678);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_digits", 32'(digits), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    accept(305);   wait_done(-1, 0); post_check();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
